// File: rtl/preempt_scheduler.sv
// preempt_scheduler
//   Emergency-vehicle preemption front end for the intersection phase
//   controller. Four approach requests are arbitrated round-robin; the winner
//   gets a fixed sequence of all-red clearance, green service and all-red
//   recovery while `emergency` holds the phase controller. A 1 s tick is
//   derived from sys_clk and all phase timing is counted in those ticks.
//
// Ports
//   sys_clk       in   system clock (all logic on the rising edge)
//   sys_rst       in   synchronous active-high reset
//   preempt_en    in   global preemption enable
//   preempt_req   in   [3:0] level requests: 0 east, 1 west, 2 south, 3 north
//   emergency     out  hold to the phase controller for the whole sequence
//   all_red       out  high during CLEAR and RECOVER
//   grant         out  [3:0] one-hot green grant, nonzero only in SERVE
//   busy          out  high whenever the sequencer is not idle
//   remain_time   out  [5:0] whole ticks left in the current phase
//   tick_1s       out  one-cycle pulse every TICK_DIV cycles
//   preempt_cnt   out  [7:0] completed/aborted sequences, saturating at 255
//   dbg_state     out  [1:0] current sequencer state for observation
module preempt_scheduler #(
    parameter int TICK_DIV     = 2500,
    parameter int CLEAR_TIME   = 5,
    parameter int SERVE_MIN    = 10,
    parameter int SERVE_MAX    = 30,
    parameter int RECOVER_TIME = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       preempt_en,
    input  logic [3:0] preempt_req,
    output logic       emergency,
    output logic       all_red,
    output logic [3:0] grant,
    output logic       busy,
    output logic [5:0] remain_time,
    output logic       tick_1s,
    output logic [7:0] preempt_cnt,
    output logic [1:0] dbg_state
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] C_TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [5:0] C_CLEAR   = 6'(CLEAR_TIME);
    localparam logic [5:0] C_MIN     = 6'(SERVE_MIN);
    localparam logic [5:0] C_MAX     = 6'(SERVE_MAX);
    localparam logic [5:0] C_RECOVER = 6'(RECOVER_TIME);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_SERVE   = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_tick_cnt;
    logic [1:0]    r_rr_ptr;
    logic [1:0]    r_winner;
    logic [5:0]    r_elapsed;
    logic [5:0]    r_remain;
    logic [3:0]    r_grant;
    logic          r_emergency;
    logic          r_all_red;
    logic          r_busy;
    logic [7:0]    r_cnt;

    state_t        w_state_nx;
    logic [TW-1:0] w_tick_nx;
    logic [1:0]    w_rr_nx;
    logic [1:0]    w_winner_nx;
    logic [5:0]    w_elapsed_nx;
    logic [5:0]    w_remain_nx;
    logic [3:0]    w_grant_nx;
    logic          w_emergency_nx;
    logic          w_all_red_nx;
    logic [7:0]    w_cnt_nx;
    logic          w_tick;
    logic          w_to_recover;
    logic [5:0]    w_elapsed_inc;
    logic          w_found;
    logic [1:0]    w_pick;

    assign w_tick        = (r_tick_cnt == C_TICK_LAST);
    assign w_elapsed_inc = r_elapsed + 6'd1;

    // Round-robin pick: first set request scanning upward from r_rr_ptr.
    always_comb begin
        logic [1:0] idx;
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        idx     = r_rr_ptr;
        for (int i = 0; i < 4; i++) begin
            idx = r_rr_ptr + 2'(i);
            if (!w_found && preempt_req[idx]) begin
                w_found = 1'b1;
                w_pick  = idx;
            end
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_tick_nx      = w_tick ? '0 : r_tick_cnt + TW'(1);
        w_rr_nx        = r_rr_ptr;
        w_winner_nx    = r_winner;
        w_elapsed_nx   = r_elapsed;
        w_remain_nx    = r_remain;
        w_grant_nx     = r_grant;
        w_emergency_nx = r_emergency;
        w_all_red_nx   = r_all_red;
        w_cnt_nx       = r_cnt;
        w_to_recover   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (preempt_en && w_found) begin
                    w_state_nx     = S_CLEAR;
                    w_winner_nx    = w_pick;
                    // Restart the tick so every phase is a whole number of ticks.
                    w_tick_nx      = '0;
                    w_emergency_nx = 1'b1;
                    w_all_red_nx   = 1'b1;
                    w_grant_nx     = 4'b0000;
                    w_remain_nx    = C_CLEAR;
                end
            end
            S_CLEAR: begin
                if (!preempt_en) begin
                    w_to_recover = 1'b1;
                end else if (w_tick) begin
                    if (r_remain == 6'd1) begin
                        w_state_nx   = S_SERVE;
                        w_grant_nx   = 4'b0001 << r_winner;
                        w_all_red_nx = 1'b0;
                        w_elapsed_nx = 6'd0;
                        w_remain_nx  = C_MAX;
                    end else begin
                        w_remain_nx = r_remain - 6'd1;
                    end
                end
            end
            S_SERVE: begin
                if (!preempt_en) begin
                    w_to_recover = 1'b1;
                end else if (w_tick) begin
                    // Request is only honoured once the minimum green has run.
                    if ((w_elapsed_inc >= C_MIN && !preempt_req[r_winner]) ||
                        (w_elapsed_inc == C_MAX)) begin
                        w_to_recover = 1'b1;
                    end else begin
                        w_elapsed_nx = w_elapsed_inc;
                        w_remain_nx  = r_remain - 6'd1;
                    end
                end
            end
            S_RECOVER: begin
                if (w_tick) begin
                    if (r_remain == 6'd1) begin
                        w_state_nx     = S_IDLE;
                        w_emergency_nx = 1'b0;
                        w_all_red_nx   = 1'b0;
                        w_remain_nx    = 6'd0;
                        w_rr_nx        = r_winner + 2'd1;
                        w_cnt_nx       = (r_cnt != 8'hFF) ? r_cnt + 8'd1 : r_cnt;
                    end else begin
                        w_remain_nx = r_remain - 6'd1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // Shared entry into RECOVER. On a tick-driven exit the counter wraps to
        // zero anyway, so forcing it here makes the enable-drop path identical.
        if (w_to_recover) begin
            w_state_nx   = S_RECOVER;
            w_grant_nx   = 4'b0000;
            w_all_red_nx = 1'b1;
            w_remain_nx  = C_RECOVER;
            w_tick_nx    = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_tick_cnt  <= '0;
            r_rr_ptr    <= 2'd0;
            r_winner    <= 2'd0;
            r_elapsed   <= 6'd0;
            r_remain    <= 6'd0;
            r_grant     <= 4'b0000;
            r_emergency <= 1'b0;
            r_all_red   <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= 8'd0;
        end else begin
            r_state     <= w_state_nx;
            r_tick_cnt  <= w_tick_nx;
            r_rr_ptr    <= w_rr_nx;
            r_winner    <= w_winner_nx;
            r_elapsed   <= w_elapsed_nx;
            r_remain    <= w_remain_nx;
            r_grant     <= w_grant_nx;
            r_emergency <= w_emergency_nx;
            r_all_red   <= w_all_red_nx;
            r_busy      <= w_emergency_nx;
            r_cnt       <= w_cnt_nx;
        end
    end

    assign emergency   = r_emergency;
    assign all_red     = r_all_red;
    assign grant       = r_grant;
    assign busy        = r_busy;
    assign remain_time = r_remain;
    assign tick_1s     = w_tick;
    assign preempt_cnt = r_cnt;
    assign dbg_state   = r_state;

    a_grant_onehot: assert property (@(posedge sys_clk) disable iff (sys_rst)
        $onehot0(grant));
    a_grant_safe: assert property (@(posedge sys_clk) disable iff (sys_rst)
        (grant != 4'b0000) |-> (emergency && !all_red));
    a_busy_emerg: assert property (@(posedge sys_clk) disable iff (sys_rst)
        busy == emergency);
endmodule

// File: tb/tb_preempt_scheduler.sv
// Bench for preempt_scheduler with TICK_DIV=4. Inputs are driven one cycle at
// a time; a time-based reference model (phase kind + phase start cycle) turns
// each cycle's inputs into the expected registered outputs, which go into
// exp_q. A negedge monitor pops one entry per cycle and compares.
module tb_preempt_scheduler;
    localparam int TD    = 4;
    localparam int CLR_T = 5;
    localparam int S_MIN = 10;
    localparam int S_MAX = 30;
    localparam int REC_T = 3;
    localparam int W     = 22;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       preempt_en;
    logic [3:0] preempt_req;
    logic       emergency;
    logic       all_red;
    logic [3:0] grant;
    logic       busy;
    logic [5:0] remain_time;
    logic       tick_1s;
    logic [7:0] preempt_cnt;
    logic [1:0] dbg_state;

    preempt_scheduler #(
        .TICK_DIV(TD), .CLEAR_TIME(CLR_T), .SERVE_MIN(S_MIN),
        .SERVE_MAX(S_MAX), .RECOVER_TIME(REC_T)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .preempt_en(preempt_en),
        .preempt_req(preempt_req), .emergency(emergency), .all_red(all_red),
        .grant(grant), .busy(busy), .remain_time(remain_time),
        .tick_1s(tick_1s), .preempt_cnt(preempt_cnt), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 sys_clk = ~sys_clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 clear, 2 serve, 3 recover. Every phase begins with the
    // tick counter at zero, so m_start is also the tick origin.
    int m_phase = 0;
    int m_start = 0;
    int m_cyc   = 0;
    int m_win   = 0;
    int m_rr    = 0;
    int m_cnt   = 0;

    task automatic model_edge(input logic rst, input logic en, input logic [3:0] req);
        int k;
        int n;
        int done;
        int rem;
        bit tick;
        logic [3:0] g;
        logic [W-1:0] v;
        k    = m_cyc - m_start;
        tick = ((k % TD) == TD - 1);
        n    = k / TD;
        if (rst) begin
            m_phase = 0; m_start = m_cyc + 1; m_rr = 0; m_win = 0; m_cnt = 0;
        end else begin
            case (m_phase)
                0: if (en && req != 4'b0000) begin
                    for (int j = 3; j >= 0; j--)
                        if (req[(m_rr + j) % 4]) m_win = (m_rr + j) % 4;
                    m_phase = 1; m_start = m_cyc + 1;
                end
                1: if (!en) begin
                    m_phase = 3; m_start = m_cyc + 1;
                end else if (tick && n + 1 == CLR_T) begin
                    m_phase = 2; m_start = m_cyc + 1;
                end
                2: if (!en || (tick && ((n + 1 >= S_MIN && !req[m_win]) || n + 1 == S_MAX))) begin
                    m_phase = 3; m_start = m_cyc + 1;
                end
                default: if (tick && n + 1 == REC_T) begin
                    m_phase = 0; m_start = m_cyc + 1;
                    m_rr = (m_win + 1) % 4;
                    if (m_cnt < 255) m_cnt++;
                end
            endcase
        end
        m_cyc++;
        k    = m_cyc - m_start;
        done = k / TD;
        case (m_phase)
            1:       rem = CLR_T - done;
            2:       rem = S_MAX - done;
            3:       rem = REC_T - done;
            default: rem = 0;
        endcase
        g = (m_phase == 2) ? (4'b0001 << m_win) : 4'b0000;
        v = {m_phase != 0, (m_phase == 1 || m_phase == 3), g, m_phase != 0,
             6'(rem), ((k % TD) == TD - 1), 8'(m_cnt)};
        exp_q.push_back(v);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic en, input logic [3:0] req);
        sys_rst     = rst;
        preempt_en  = en;
        preempt_req = req;
        model_edge(rst, en, req);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run(input int cycles, input logic en, input logic [3:0] req);
        for (int i = 0; i < cycles; i++) step(1'b0, en, req);
    endtask

    // ---------------- monitor ----------------
    always @(negedge sys_clk) begin
        logic [W-1:0] e;
        logic [W-1:0] got;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {emergency, all_red, grant, busy, remain_time, tick_1s, preempt_cnt};
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL out_vec t=%0t got em=%b ar=%b gr=%b bz=%b rt=%0d tk=%b pc=%0d exp em=%b ar=%b gr=%b bz=%b rt=%0d tk=%b pc=%0d",
                         $time, got[21], got[20], got[19:16], got[15], got[14:9], got[8], got[7:0],
                         e[21], e[20], e[19:16], e[15], e[14:9], e[8], e[7:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] r_req;
        logic       r_en;
        logic       r_rst;

        // Reset, then south held: full-length service.
        step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b0, 4'b0000);
        run(153, 1'b1, 4'b0100);
        run(5, 1'b1, 4'b0000);

        // East pulsed for 10 cycles: minimum-length service.
        run(10, 1'b1, 4'b0001);
        run(80, 1'b1, 4'b0000);

        // All requests held: rotating winners, back-to-back sequences.
        run(770, 1'b1, 4'b1111);
        run(160, 1'b1, 4'b0000);

        // Enable dropped 8 cycles into SERVE.
        run(29, 1'b1, 4'b0010);
        step(1'b0, 1'b0, 4'b0000);
        run(20, 1'b1, 4'b0000);

        // Reset mid-SERVE with requests held; restart from rr_ptr=0.
        run(35, 1'b1, 4'b1001);
        step(1'b1, 1'b1, 4'b1001);
        run(160, 1'b1, 4'b1001);
        run(160, 1'b1, 4'b0000);

        // 256 short (enable-aborted) sequences to saturate the counter.
        for (int i = 0; i < 256; i++) begin
            r_req = 4'($urandom_range(1, 15));
            run(2, 1'b1, r_req);
            run(13, 1'b0, 4'($urandom_range(0, 15)));
        end
        run(80, 1'b1, 4'b0001);

        // Random traffic: sticky requests, occasional enable drops and resets.
        r_req = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) r_req = 4'($urandom_range(0, 15));
            r_en  = ($urandom_range(0, 99) < 97);
            r_rst = ($urandom_range(0, 999) == 0);
            step(r_rst, r_en, r_req);
        end

        @(negedge sys_clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
